// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix scanner, full-scan debounce, one-cycle key codes.
// Define KEYPAD_AUTOREPEAT_EN to re-emit a held key at a timed rate.
module keypad_scan #(
  parameter int SCAN_DIV       = 1200,
  parameter int DEBOUNCE_SCANS = 50,
  parameter int REPEAT_DELAY   = 1250,
  parameter int REPEAT_RATE    = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key
);
  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [3:0] NO_KEY = 4'd13;

  typedef enum logic [1:0] {
    IDLE, DEB_PRESS, HELD, DEB_REL
  } state_t;

  // the synchronizer needs two dwell cycles to settle on a new column
  if (SCAN_DIV < 3 || DEBOUNCE_SCANS < 1 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("keypad_scan: parameter out of range");
  end

  logic [3:0]    sync1;
  logic [3:0]    row_s;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic [15:0]   snap;
  logic [15:0]   cur;
  logic [15:0]   full;
  logic [15:0]   masked;
  logic          last;
  logic          eval;
  logic [4:0]    ones;
  logic [3:0]    hit;
  logic [3:0]    scan_code;
  logic          single;
  logic          none;

  assign last = (dwell == DW'(SCAN_DIV - 1));
  assign eval = last && (col_idx == 2'd3);
  assign col  = ~(4'b0001 << col_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      row_s   <= '0;
      dwell   <= '0;
      col_idx <= '0;
      snap    <= '0;
    end else begin
      sync1 <= row;
      row_s <= sync1;
      if (last) begin
        dwell   <= '0;
        col_idx <= col_idx + 2'd1;
        snap    <= eval ? '0 : full;
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  always_comb begin
    cur = '0;
    for (int r = 0; r < 4; r++) begin
      cur[{2'(r), col_idx}] = ~row_s[r];
    end
  end

  assign full   = snap | cur;
  // row3/col3 has no legend on the keypad
  assign masked = full & 16'h7fff;

  always_comb begin
    ones = '0;
    hit  = '0;
    for (int i = 0; i < 16; i++) begin
      if (masked[i]) begin
        ones = ones + 5'd1;
        hit  = 4'(i);
      end
    end
  end

  assign single = (ones == 5'd1);
  assign none   = (ones == 5'd0);

  always_comb begin
    unique case (hit)
      4'd0:    scan_code = 4'd1;
      4'd1:    scan_code = 4'd2;
      4'd2:    scan_code = 4'd3;
      4'd3:    scan_code = 4'd10;
      4'd4:    scan_code = 4'd4;
      4'd5:    scan_code = 4'd5;
      4'd6:    scan_code = 4'd6;
      4'd7:    scan_code = 4'd11;
      4'd8:    scan_code = 4'd7;
      4'd9:    scan_code = 4'd8;
      4'd10:   scan_code = 4'd9;
      4'd11:   scan_code = 4'd12;
      4'd12:   scan_code = 4'd15;
      4'd13:   scan_code = 4'd0;
      4'd14:   scan_code = 4'd14;
      default: scan_code = NO_KEY;
    endcase
  end

  state_t        state_q, state_d;
  logic [3:0]    code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    key_q, key_d;
  logic          arm;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RMAX =
    (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);

  logic          rep_on_q, rep_on_d;
  logic          rep_first_q, rep_first_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic [RW-1:0] rep_lim;

  assign rep_lim = rep_first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_on_q    <= 1'b0;
      rep_first_q <= 1'b0;
      rep_cnt_q   <= '0;
    end else begin
      rep_on_q    <= rep_on_d;
      rep_first_q <= rep_first_d;
      rep_cnt_q   <= rep_cnt_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      cnt_q   <= '0;
      key_q   <= NO_KEY;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    key_d   = NO_KEY;
    arm     = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_on_d    = rep_on_q;
    rep_first_d = rep_first_q;
    rep_cnt_d   = rep_cnt_q;
`endif
    if (eval) begin
      unique case (state_q)
        IDLE: begin
          if (single) begin
            code_d  = scan_code;
            cnt_d   = CW'(1);
            state_d = DEB_PRESS;
            arm     = (DEBOUNCE_SCANS <= 1);
          end
        end
        DEB_PRESS: begin
          if (single && scan_code == code_q) begin
            cnt_d = cnt_q + 1'b1;
            arm   = (cnt_d == CW'(DEBOUNCE_SCANS));
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (none) begin
            cnt_d   = CW'(1);
            state_d = (DEBOUNCE_SCANS <= 1) ? IDLE : DEB_REL;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_on_d = 1'b0;
          end else if (single && scan_code == code_q && rep_on_q) begin
            rep_cnt_d = rep_cnt_q + 1'b1;
            if (rep_cnt_d == rep_lim) begin
              key_d       = code_q;
              rep_cnt_d   = '0;
              rep_first_d = 1'b0;
            end
          end else begin
            rep_on_d = 1'b0;
`endif
          end
        end
        DEB_REL: begin
          if (none) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CW'(DEBOUNCE_SCANS)) state_d = IDLE;
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
      if (arm) begin
        key_d   = code_d;
        state_d = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_on_d    = 1'b1;
        rep_first_d = 1'b1;
        rep_cnt_d   = '0;
`endif
      end
    end
  end

  assign key = key_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: keypad matrix model, scan-level reference, scoreboard.
// Build with KEYPAD_AUTOREPEAT_EN to exercise repeat expectations.
module tb_keypad_scan;
  localparam int SD = 4;
  localparam int DB = 3;
  localparam int RD = 4;
  localparam int RR = 2;
  localparam int SCAN = 4 * SD;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  typedef struct {
    int code;
    int at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key;
  logic [15:0] pressed = '0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];
  exp_t        got;
  int          kmap[16] = '{1, 2, 3, 10, 4, 5, 6, 11,
                            7, 8, 9, 12, 15, 0, 14, -1};

  bit armed = 1'b1;
  int run_code = -1;
  int run_len = 0;
  int none_run = 0;
  bit rep_live = 1'b0;
  int held_len = 0;

  keypad_scan #(
    .SCAN_DIV(SD), .DEBOUNCE_SCANS(DB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .key(key)
  );

  always #5 clk = ~clk;

  // passive matrix: a pressed key ties its row to the driven-low column
  always_comb begin
    row = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  function automatic logic [3:0] exp_col(input int t);
    logic [3:0] v;
    v = 4'b1111;
    v[(t / SD) % 4] = 1'b0;
    return v;
  endfunction

  task automatic push(input int code, input int at);
    exp_t e;
    e.code = code;
    e.at = at;
    q.push_back(e);
  endtask

  task automatic model_reset();
    armed = 1'b1;
    run_len = 0;
    none_run = 0;
    rep_live = 1'b0;
    held_len = 0;
  endtask

  // one completed scan: classify the held key set, predict any emission
  task automatic model_scan(input logic [15:0] keys, input int at);
    logic [15:0] m;
    int n;
    int c;
    m = keys & 16'h7fff;
    n = $countones(m);
    c = -1;
    for (int i = 0; i < 16; i++) if (n == 1 && m[i]) c = kmap[i];
    if (armed) begin
      if (n == 1 && run_len > 0 && c == run_code) run_len++;
      else if (n == 1 && run_len == 0) begin
        run_code = c;
        run_len = 1;
      end else run_len = 0;
      if (run_len == DB) begin
        push(c, at);
        armed = 1'b0;
        none_run = 0;
        rep_live = 1'b1;
        held_len = 0;
      end
    end else begin
      if (n == 0) none_run++;
      else none_run = 0;
      if (n == 1 && c == run_code && rep_live) begin
        held_len++;
        if (REP && (held_len == RD ||
            (held_len > RD && (held_len - RD) % RR == 0)))
          push(c, at);
      end else rep_live = 1'b0;
      if (none_run == DB) begin
        armed = 1'b1;
        run_len = 0;
      end
    end
  endtask

  task automatic run_scan(input logic [15:0] keys);
    pressed = keys;
    repeat (SCAN) @(posedge clk);
    #1;
    model_scan(keys, cyc);
  endtask

  task automatic scans(input logic [15:0] keys, input int n);
    for (int i = 0; i < n; i++) run_scan(keys);
  endtask

  always @(negedge clk) begin
    checks++;
    if (col !== exp_col(cyc)) begin
      errors++;
      $display("FAIL col t=%0d got %b want %b", cyc, col, exp_col(cyc));
    end
    if (key !== 4'd13) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL spurious_key t=%0d got %0d want 13", cyc, key);
      end else begin
        got = q.pop_front();
        if (int'(key) != got.code || cyc != got.at) begin
          errors++;
          $display("FAIL key got %0d@%0d want %0d@%0d",
                   key, cyc, got.code, got.at);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (col !== 4'b1110 || key !== 4'd13) begin
      errors++;
      $display("FAIL reset col=%b key=%0d want 1110/13", col, key);
    end
    model_reset();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  logic [15:0] rk;
  int kind;

  initial begin
    #1;
    do_reset();
    scans(16'h0000, 13);
    scans(16'h0020, 4);
    scans(16'h0000, 4);
    run_scan(16'h0020);
    run_scan(16'h0000);
    scans(16'h0020, 4);
    scans(16'h0000, 4);
    scans(16'h0300, 5);
    scans(16'h0200, 4);
    scans(16'h0000, 4);
    scans(16'h8000, 4);
    scans(16'h8001, 4);
    scans(16'h0000, 4);
    scans(16'h0004, 4);
    scans(16'h0044, 2);
    scans(16'h0040, 3);
    scans(16'h0000, 4);
    rk = '0;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      if (kind == 0) rk = '0;
      else if (kind == 1) rk = 16'h1 << $urandom_range(0, 15);
      else if (kind == 2)
        rk = (16'h1 << $urandom_range(0, 15)) |
             (16'h1 << $urandom_range(0, 15));
      scans(rk, $urandom_range(1, 5));
    end
    scans(16'h0000, 4);
    scans(16'h1000, 2);
    do_reset();
    run_scan(16'h1000);
    scans(16'h0000, 4);
    scans(16'h2000, 12);
    scans(16'h0000, 4);
    repeat (4) @(posedge clk);
    #1;
    while (q.size() > 0) begin
      got = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_key got none want %0d@%0d", got.code, got.at);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
